// File: rtl/dsa_bilinear_datapath.sv
// ============================================================================
// dsa_bilinear_datapath
// ----------------------------------------------------------------------------
// Sequential bilinear interpolator for the DSA image scaler. A 2x2 pixel
// neighbourhood and Q8.8 fractional offsets (a along x, b along y) are
// captured on an accepted start. One shared multiply-accumulate unit then
// evaluates the result over six MAC cycles:
//   T0/T1 : top = p00*(1-wa) + p01*wa
//   B0/B1 : bot = p10*(1-wa) + p11*wa
//   V0/V1 : acc = top*(1-wb) + bot*wb
// The result is scaled back by 2*FRAC_W, saturated to the pixel range and
// registered into pixel_out when the FSM enters DONE.
//
// Build option:
//   DSA_ROUND_EN  defined   -> the final shift rounds half up
//                 undefined -> the final shift truncates
//   Latency, ports and FSM are identical in both builds.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   start      in   request, sampled only in IDLE
//   p00..p11   in   PIX_W   neighbourhood pixels (top-left, top-right,
//                           bottom-left, bottom-right)
//   a, b       in   COORD_W x / y fraction, values above 1.0 act as 1.0
//   pixel_out  out  PIX_W   registered result, held until the next DONE
//   done       out  1       high for exactly the DONE cycle
//   busy       out  1       high from accepted start through DONE
// ============================================================================
module dsa_bilinear_datapath #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 16,
  parameter int FRAC_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PIX_W-1:0]   p00,
  input  logic [PIX_W-1:0]   p01,
  input  logic [PIX_W-1:0]   p10,
  input  logic [PIX_W-1:0]   p11,
  input  logic [COORD_W-1:0] a,
  input  logic [COORD_W-1:0] b,
  output logic [PIX_W-1:0]   pixel_out,
  output logic               done,
  output logic               busy
);

  localparam int W_W   = FRAC_W + 1;              // clamped weight, 0..1.0
  localparam int H_W   = PIX_W + FRAC_W + 1;      // one row sum (top/bot)
  localparam int ACC_W = H_W + W_W;               // full accumulator
  localparam int SH_W  = ACC_W - 2 * FRAC_W;      // integer part after shift

  localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1) << FRAC_W;
  localparam logic [W_W-1:0]     ONE_W = W_W'(1) << FRAC_W;
`ifdef DSA_ROUND_EN
  localparam logic [ACC_W-1:0]   HALF  = ACC_W'(1) << (2 * FRAC_W - 1);
`endif

  typedef enum logic [2:0] {IDLE, T0, T1, B0, B1, V0, V1, DONE} state_t;

  state_t state, state_next;

  logic [PIX_W-1:0] p00_r, p01_r, p10_r, p11_r;
  logic [W_W-1:0]   wa_r, wb_r;
  logic [H_W-1:0]   top_r, bot_r;
  logic [ACC_W-1:0] acc_r;

  logic [H_W-1:0]   mul_a;
  logic [W_W-1:0]   mul_w;
  logic             clear;
  logic [ACC_W-1:0] prod, mac_sum, rounded;
  logic [SH_W-1:0]  shifted;
  logic [PIX_W-1:0] pix_next;
  logic [W_W-1:0]   wa_clamp, wb_clamp;

  // Weights are clamped once at capture so the MAC only ever sees 0..1.0.
  assign wa_clamp = (a > ONE_C) ? ONE_W : a[W_W-1:0];
  assign wb_clamp = (b > ONE_C) ? ONE_W : b[W_W-1:0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state and status outputs
  // --------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = T0;
      end
      T0:   state_next = T1;
      T1:   state_next = B0;
      B0:   state_next = B1;
      B1:   state_next = V0;
      V0:   state_next = V1;
      V1:   state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shared MAC operand select. The first step of each pair starts from zero.
  // --------------------------------------------------------------------------
  always_comb begin
    mul_a = '0;
    mul_w = '0;
    clear = 1'b0;
    case (state)
      T0: begin mul_a = H_W'(p00_r); mul_w = ONE_W - wa_r; clear = 1'b1; end
      T1: begin mul_a = H_W'(p01_r); mul_w = wa_r;                       end
      B0: begin mul_a = H_W'(p10_r); mul_w = ONE_W - wa_r; clear = 1'b1; end
      B1: begin mul_a = H_W'(p11_r); mul_w = wa_r;                       end
      V0: begin mul_a = top_r;       mul_w = ONE_W - wb_r; clear = 1'b1; end
      V1: begin mul_a = bot_r;       mul_w = wb_r;                       end
      default: ;
    endcase
    prod    = ACC_W'(mul_a) * ACC_W'(mul_w);
    mac_sum = (clear ? '0 : acc_r) + prod;
  end

  // Final scaling, applied to the last MAC sum in V1. Saturation follows the
  // optional rounding so a rounded-up 255.5 still clips to full scale.
  always_comb begin
`ifdef DSA_ROUND_EN
    rounded = mac_sum + HALF;
`else
    rounded = mac_sum;
`endif
    shifted  = SH_W'(rounded >> (2 * FRAC_W));
    pix_next = (|shifted[SH_W-1:PIX_W]) ? '1 : shifted[PIX_W-1:0];
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // NOTE: operand and intermediate registers are reset along with the FSM so
  // an aborted computation leaves no stale partial sums behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p00_r     <= '0;
      p01_r     <= '0;
      p10_r     <= '0;
      p11_r     <= '0;
      wa_r      <= '0;
      wb_r      <= '0;
      top_r     <= '0;
      bot_r     <= '0;
      acc_r     <= '0;
      pixel_out <= '0;
    end else begin
      if (state == IDLE && start) begin
        p00_r <= p00;
        p01_r <= p01;
        p10_r <= p10;
        p11_r <= p11;
        wa_r  <= wa_clamp;
        wb_r  <= wb_clamp;
      end
      if (state != IDLE && state != DONE) acc_r <= mac_sum;
      if (state == T1) top_r     <= mac_sum[H_W-1:0];
      if (state == B1) bot_r     <= mac_sum[H_W-1:0];
      if (state == V1) pixel_out <= pix_next;
    end
  end

endmodule

// File: tb/tb_dsa_bilinear_datapath.sv
// ============================================================================
// tb_dsa_bilinear_datapath
// ----------------------------------------------------------------------------
// Self-checking bench for dsa_bilinear_datapath. A table of directed vectors
// covers the documented cases and corners; randomized operations are scored
// against a closed-form weighted-sum model of the interpolation. Hand-written
// sequences cover mid-operation reset, ignored starts while busy and a start
// held through the DONE cycle. Define DSA_ROUND_EN for both DUT and bench to
// check the rounding build.
// ============================================================================
module tb_dsa_bilinear_datapath;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  p00, p01, p10, p11;
  logic [15:0] a, b;
  logic [7:0]  pixel_out;
  logic        done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  dsa_bilinear_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .p00       (p00),
    .p01       (p01),
    .p10       (p10),
    .p11       (p11),
    .a         (a),
    .b         (b),
    .pixel_out (pixel_out),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p00, p01, p10, p11;
    int a, b;
    int exp_pix;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Closed-form reference: each pixel weighted by the product of its x and y
  // weights, then scaled back from Q16 with the build's rounding rule.
  function automatic int model(input vec_t v);
    int wa, wb, r;
    longint acc;
    wa  = (v.a > 256) ? 256 : v.a;
    wb  = (v.b > 256) ? 256 : v.b;
    acc = longint'(v.p00) * (256 - wa) * (256 - wb)
        + longint'(v.p01) * wa * (256 - wb)
        + longint'(v.p10) * (256 - wa) * wb
        + longint'(v.p11) * wa * wb;
`ifdef DSA_ROUND_EN
    acc = acc + 32768;
`endif
    r = int'(acc / 65536);
    return (r > 255) ? 255 : r;
  endfunction

  task automatic scramble_inputs();
    p00 = 8'($urandom);
    p01 = 8'($urandom);
    p10 = 8'($urandom);
    p11 = 8'($urandom);
    a   = 16'($urandom);
    b   = 16'($urandom);
  endtask

  // Issue one request and wait (bounded) for done. Inputs are scrambled right
  // after the start edge. With pulse_start, start toggles randomly while busy
  // and is held high through the DONE cycle; none of that may be accepted.
  task automatic run_op(input vec_t v, input bit pulse_start, input string tag,
                        output int pix);
    int lat;
    int busy_low;
    @(negedge clk);
    p00 = 8'(v.p00); p01 = 8'(v.p01); p10 = 8'(v.p10); p11 = 8'(v.p11);
    a   = 16'(v.a);  b   = 16'(v.b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    lat      = -1;
    busy_low = 0;
    pix      = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (done) begin
        lat = k;
        pix = int'(pixel_out);
        break;
      end
      if (pulse_start) start = 1'($urandom);
    end
    check({tag, " latency"}, lat, 7);
    check({tag, " busy low during op"}, busy_low, 0);
    if (pulse_start) start = 1'b1;     // held through DONE: must be ignored
    @(negedge clk);
    check({tag, " busy after done"}, int'(busy), 0);
    check({tag, " single done"}, int'(done), 0);
    check({tag, " pixel held"}, int'(pixel_out), pix);
    start = 1'b0;
  endtask

  vec_t tbl[9];
  vec_t rv;
  int   got;

  initial begin
    tbl[0] = '{100, 120, 140, 160, 'h0080, 'h0080, 130};
`ifdef DSA_ROUND_EN
    tbl[1] = '{50, 150, 100, 200, 'h0040, 'h00C0, 113};
`else
    tbl[1] = '{50, 150, 100, 200, 'h0040, 'h00C0, 112};
`endif
    tbl[2] = '{10, 20, 30, 40, 'h0000, 'h0000, 10};
    tbl[3] = '{10, 20, 30, 40, 'h0100, 'h0000, 20};
    tbl[4] = '{10, 20, 30, 40, 'h0000, 'h0100, 30};
    tbl[5] = '{10, 20, 30, 40, 'h0100, 'h0100, 40};
    tbl[6] = '{0, 255, 0, 255, 'hFFFF, 'h0080, 255};
    tbl[7] = '{255, 255, 255, 255, 'h0100, 'h0100, 255};
    tbl[8] = '{10, 20, 30, 40, 'h0101, 'h0300, 40};

    rst   = 1'b0;
    start = 1'b0;
    p00 = '0; p01 = '0; p10 = '0; p11 = '0; a = '0; b = '0;
    #1;
    check("reset pixel_out", int'(pixel_out), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed table.
    foreach (tbl[i]) begin
      run_op(tbl[i], 1'b0, $sformatf("vec%0d", i), got);
      check($sformatf("vec%0d pixel", i), got, tbl[i].exp_pix);
    end

    // Mid-operation reset: outputs clear immediately, FSM back in IDLE.
    @(negedge clk);
    p00 = 8'd100; p01 = 8'd120; p10 = 8'd140; p11 = 8'd160;
    a = 16'h0080; b = 16'h0080;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midop reset pixel_out", int'(pixel_out), 0);
    check("midop reset done", int'(done), 0);
    check("midop reset busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post reset idle busy", int'(busy), 0);
    check("post reset idle done", int'(done), 0);
    check("post reset pixel_out", int'(pixel_out), 0);
    run_op(tbl[0], 1'b0, "post reset op", got);
    check("post reset op pixel", got, tbl[0].exp_pix);

    // Start pulsed while busy and held through DONE.
    run_op(tbl[1], 1'b1, "pulsed start", got);
    check("pulsed start pixel", got, tbl[1].exp_pix);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rv.p00 = int'($urandom_range(0, 255));
      rv.p01 = int'($urandom_range(0, 255));
      rv.p10 = int'($urandom_range(0, 255));
      rv.p11 = int'($urandom_range(0, 255));
      rv.a   = (i % 5 == 0) ? int'($urandom_range(0, 65535))
                            : int'($urandom_range(0, 300));
      rv.b   = (i % 7 == 0) ? int'($urandom_range(0, 65535))
                            : int'($urandom_range(0, 300));
      rv.exp_pix = model(rv);
      run_op(rv, (i % 4 == 0), $sformatf("rand%0d", i), got);
      check($sformatf("rand%0d pixel", i), got, rv.exp_pix);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
